// File: rtl/asteroids_pkg.sv
// Shared asteroids-game types and helpers: default sprite counts, hit vectors
// and a popcount also used by the rock manager.
package asteroids_pkg;
  localparam int N_TORP_DEF = 4;
  localparam int N_ROCK_DEF = 8;

  typedef logic [N_ROCK_DEF-1:0] hit_vec_t;

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int k = 0; k < 64; k++) c += 32'(v[k]);
    return c;
  endfunction
endpackage

// File: rtl/torpedo_hit_detector_if.sv
// Hit interface between the sprite chain / torpedo units (master) and the
// hit detector (slave).
interface torpedo_hit_detector_if import asteroids_pkg::*; #(
  parameter int N_TORP  = N_TORP_DEF,
  parameter int N_ROCK  = N_ROCK_DEF,
  parameter int SCORE_W = 16
);
  localparam int FH_W = $clog2(N_ROCK + 1);

  logic                vsync;
  logic                pix_valid;
  logic [N_TORP-1:0]   torp_draw;
  logic [N_ROCK-1:0]   rock_draw;
  logic                ship_draw;
  logic [N_TORP-1:0]   torp_alive;
  logic [N_TORP-1:0]   hit_torp;
  logic [N_ROCK-1:0]   hit_rock;
  logic                ship_hit;
  logic [SCORE_W-1:0]  score;
  logic [FH_W-1:0]     frame_hits;

  modport master (
    output vsync, pix_valid, torp_draw, rock_draw, ship_draw, torp_alive,
    input  hit_torp, hit_rock, ship_hit, score, frame_hits
  );
  modport slave (
    input  vsync, pix_valid, torp_draw, rock_draw, ship_draw, torp_alive,
    output hit_torp, hit_rock, ship_hit, score, frame_hits
  );
endinterface

// File: rtl/hit_claim_arbiter.sv
// Each torpedo claims its lowest-index overlapping rock; rocks hit by any
// torpedo are ORed per column and counted.
module hit_claim_arbiter import asteroids_pkg::*; #(
  parameter int N_TORP = N_TORP_DEF,
  parameter int N_ROCK = N_ROCK_DEF,
  parameter int FH_W   = $clog2(N_ROCK + 1)
) (
  input  logic [N_TORP-1:0][N_ROCK-1:0] m,
  output logic [N_TORP-1:0]             torp_hit,
  output logic [N_ROCK-1:0]             rock_hit,
  output logic [FH_W-1:0]               n_hits
);
  logic [N_ROCK-1:0] claim;

  always_comb begin
    torp_hit = '0;
    rock_hit = '0;
    claim    = '0;
    for (int i = 0; i < N_TORP; i++) begin
      // x & -x isolates the lowest set bit of the row
      claim       = m[i] & (~m[i] + N_ROCK'(1));
      torp_hit[i] = |claim;
      rock_hit    = rock_hit | claim;
    end
  end

  assign n_hits = FH_W'(popcount(64'(rock_hit)));
endmodule

// File: rtl/torpedo_hit_detector.sv
// Accumulates torpedo/rock and ship/rock overlaps over a frame and, one cycle
// after vsync, pulses hits back to torpedoes and rocks and updates the score.
module torpedo_hit_detector import asteroids_pkg::*; #(
  parameter int N_TORP  = N_TORP_DEF,
  parameter int N_ROCK  = N_ROCK_DEF,
  parameter int SCORE_W = 16
) (
  input logic                  clk,
  input logic                  resetN,
  torpedo_hit_detector_if.slave hd
);
  localparam int FH_W = $clog2(N_ROCK + 1);

  logic                         s_pix_valid, s_ship_draw, vsync_d1;
  logic [N_TORP-1:0]            s_torp_draw;
  logic [N_ROCK-1:0]            s_rock_draw;
  logic [N_TORP-1:0][N_ROCK-1:0] acc, contrib, m;
  logic                         acc_ship, contrib_ship;
  logic [N_TORP-1:0]            torp_hit;
  logic [N_ROCK-1:0]            rock_hit;
  logic [FH_W-1:0]              n_hits;
  logic [SCORE_W:0]             score_sum;
  logic [SCORE_W-1:0]           score_nxt;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      s_pix_valid <= 1'b0;
      s_torp_draw <= '0;
      s_rock_draw <= '0;
      s_ship_draw <= 1'b0;
      vsync_d1    <= 1'b0;
    end else begin
      s_pix_valid <= hd.pix_valid;
      s_torp_draw <= hd.torp_draw;
      s_rock_draw <= hd.rock_draw;
      s_ship_draw <= hd.ship_draw;
      vsync_d1    <= hd.vsync;
    end
  end

  // The registered pixel in the evaluate cycle still belongs to the closing frame
  always_comb begin
    contrib = '0;
    m       = '0;
    for (int i = 0; i < N_TORP; i++) begin
      contrib[i] = (s_pix_valid && s_torp_draw[i]) ? s_rock_draw : '0;
      m[i]       = (acc[i] | contrib[i]) & {N_ROCK{hd.torp_alive[i]}};
    end
    contrib_ship = s_pix_valid & s_ship_draw & (|s_rock_draw);
  end

  hit_claim_arbiter #(.N_TORP(N_TORP), .N_ROCK(N_ROCK), .FH_W(FH_W)) u_arb (
    .m        (m),
    .torp_hit (torp_hit),
    .rock_hit (rock_hit),
    .n_hits   (n_hits)
  );

  assign score_sum = (SCORE_W+1)'(hd.score) + (SCORE_W+1)'(n_hits);
  assign score_nxt = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

  always_ff @(posedge clk) begin
    if (!resetN) begin
      acc           <= '0;
      acc_ship      <= 1'b0;
      hd.hit_torp   <= '0;
      hd.hit_rock   <= '0;
      hd.ship_hit   <= 1'b0;
      hd.score      <= '0;
      hd.frame_hits <= '0;
    end else begin
      hd.hit_torp <= vsync_d1 ? torp_hit : '0;
      hd.hit_rock <= vsync_d1 ? rock_hit : '0;
      hd.ship_hit <= vsync_d1 & (acc_ship | contrib_ship);
      if (vsync_d1) begin
        acc           <= '0;
        acc_ship      <= 1'b0;
        hd.score      <= score_nxt;
        hd.frame_hits <= n_hits;
      end else begin
        acc      <= acc | contrib;
        acc_ship <= acc_ship | contrib_ship;
      end
    end
  end
endmodule

// File: tb/tb_torpedo_hit_detector.sv
// Directed + random bench for torpedo_hit_detector against a frame-level
// overlap model; a 4-bit-score instance shares the inputs for saturation.
module tb_torpedo_hit_detector;
  import asteroids_pkg::*;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  torpedo_hit_detector_if hd ();
  torpedo_hit_detector_if #(.SCORE_W(4)) hd4 ();

  assign hd4.vsync      = hd.vsync;
  assign hd4.pix_valid  = hd.pix_valid;
  assign hd4.torp_draw  = hd.torp_draw;
  assign hd4.rock_draw  = hd.rock_draw;
  assign hd4.ship_draw  = hd.ship_draw;
  assign hd4.torp_alive = hd.torp_alive;

  torpedo_hit_detector dut (.clk(clk), .resetN(resetN), .hd(hd));
  torpedo_hit_detector #(.SCORE_W(4)) dut4 (.clk(clk), .resetN(resetN), .hd(hd4));

  int ntests = 0;
  int nfail  = 0;

  logic [3:0]     alive;
  bit [3:0][7:0]  macc, closed;
  bit             mship, cship, pend;
  logic [3:0]     e_ht;
  hit_vec_t       e_hr;
  logic           e_sh;
  int             e_fh, e_score, e_score4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: a pixel belongs to the frame closed by the first
  // vsync at or after it; that frame is judged with torp_alive of the next cycle.
  task automatic model(input logic v, input logic pv, input logic [3:0] td,
                       input logic [7:0] rd, input logic sd, input logic rst);
    bit f;
    if (!rst) begin
      macc = '0; mship = 0; pend = 0;
      e_ht = '0; e_hr = '0; e_sh = 0; e_fh = 0; e_score = 0; e_score4 = 0;
    end else begin
      e_ht = '0; e_hr = '0; e_sh = 0;
      if (pend) begin
        for (int i = 0; i < 4; i++) begin
          f = 0;
          if (alive[i])
            for (int j = 0; j < 8; j++)
              if (!f && closed[i][j]) begin f = 1; e_ht[i] = 1; e_hr[j] = 1; end
        end
        e_sh     = cship;
        e_fh     = $countones(e_hr);
        e_score  = (e_score + e_fh > 65535) ? 65535 : e_score + e_fh;
        e_score4 = (e_score4 + e_fh > 15) ? 15 : e_score4 + e_fh;
      end
      if (pv) begin
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 8; j++)
            if (td[i] && rd[j]) macc[i][j] = 1;
        if (sd && rd != 0) mship = 1;
      end
      if (v) begin
        closed = macc; cship = mship; macc = '0; mship = 0; pend = 1;
      end else pend = 0;
    end
  endtask

  task automatic step(input logic v, input logic pv, input logic [3:0] td,
                      input logic [7:0] rd, input logic sd, input logic rst);
    hd.vsync = v; hd.pix_valid = pv; hd.torp_draw = td; hd.rock_draw = rd;
    hd.ship_draw = sd; hd.torp_alive = alive; resetN = rst;
    model(v, pv, td, rd, sd, rst);
    @(posedge clk); #1;
    chk("hit_torp",   32'(hd.hit_torp),    32'(e_ht));
    chk("hit_rock",   32'(hd.hit_rock),    32'(e_hr));
    chk("ship_hit",   32'(hd.ship_hit),    32'(e_sh));
    chk("frame_hits", 32'(hd.frame_hits),  32'(e_fh));
    chk("score",      32'(hd.score),       32'(e_score));
    chk("score4",     32'(hd4.score),      32'(e_score4));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 4'h0, 8'h00, 0, 1);
  endtask

  // n pixels, torpedo k over rock k, vsync on the last pixel -> n hits
  task automatic diag_frame(input int n);
    for (int k = 0; k < n; k++)
      step(k == n - 1, 1, 4'(1 << k), 8'(1 << k), 0, 1);
  endtask

  initial begin
    alive = 4'b0001;
    step(0, 0, 4'h0, 8'h00, 0, 0);
    step(1, 1, 4'h1, 8'h08, 0, 0);
    idle(2);

    // Torpedo 0 over rock 3 for five pixels
    for (int k = 0; k < 5; k++) step(0, 1, 4'h1, 8'h08, 0, 1);
    step(1, 0, 4'h0, 8'h00, 0, 1);
    idle(3);

    // Lowest-index claim; shared rock destroyed once
    alive = 4'b0111;
    step(0, 1, 4'h2, 8'h24, 0, 1);
    step(0, 1, 4'h5, 8'h40, 0, 1);
    step(1, 0, 4'h0, 8'h00, 0, 1);
    idle(3);

    // Torpedo dies in the evaluate cycle
    alive = 4'b0001;
    step(0, 1, 4'h1, 8'h10, 0, 1);
    step(1, 0, 4'h0, 8'h00, 0, 1);
    alive = 4'b0000;
    idle(2);

    // Overlap outside active video
    alive = 4'b1111;
    step(0, 0, 4'hF, 8'hFF, 1, 1);
    step(1, 0, 4'hF, 8'hFF, 1, 1);
    idle(2);

    // Pixel in the vsync cycle, then one at vsync+1 lands in the next frame
    step(1, 1, 4'h1, 8'h01, 0, 1);
    step(0, 1, 4'h2, 8'h02, 0, 1);
    idle(1);
    step(1, 0, 4'h0, 8'h00, 0, 1);
    idle(2);

    // Back-to-back vsync
    step(1, 1, 4'h1, 8'h04, 0, 1);
    step(1, 1, 4'h8, 8'h80, 0, 1);
    idle(3);

    // Ship collision
    step(0, 1, 4'h0, 8'h01, 1, 1);
    step(1, 0, 4'h0, 8'h00, 0, 1);
    idle(2);

    // Reset mid-frame discards the frame and the score
    step(0, 1, 4'h3, 8'h30, 1, 1);
    step(0, 0, 4'h0, 8'h00, 0, 0);
    step(1, 0, 4'h0, 8'h00, 0, 1);
    idle(2);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      alive = 4'($urandom);
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, 4'($urandom),
           8'($urandom & $urandom), 1'($urandom), $urandom_range(0, 63) != 0);
    end

    // Saturation on the 4-bit score: 14, then +3 -> 15, then stays
    alive = 4'b1111;
    step(0, 0, 4'h0, 8'h00, 0, 0);
    idle(1);
    diag_frame(4); diag_frame(4); diag_frame(4); diag_frame(2);
    idle(1);
    chk("score4_at_14", 32'(hd4.score), 32'd14);
    diag_frame(3);
    idle(1);
    chk("score4_sat", 32'(hd4.score), 32'd15);
    chk("frame_hits_3", 32'(hd4.frame_hits), 32'd3);
    diag_frame(1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
